// File: rtl/fsm_controller.sv
// fsm_controller
// Fetch/decode/execute sequencer feeding the program counter. Each instruction
// is fetched from synchronous memory, latched into the instruction register,
// decoded, and executed. The final cycle of every instruction carries exactly
// one PC command: pc_add, pc_branch or pc_jump.
//
// Ports
//   clk, reset    system clock; synchronous active-high reset
//   run           1 = sequence; 0 = park in S_FETCH (only honoured there)
//   mem_rdata     memory read data, valid one cycle after the address
//   flags         {N,Z,F,L,C} from the flag register
//   ir            instruction register
//   mem_addr_sel  0 = PC addresses memory, 1 = reg[rsrc]
//   mem_we        store strobe
//   rf_we         register-file write enable
//   wb_sel        write-back source: 00 ALU, 01 mem_rdata, 10 link (PC+1)
//   rdest, rsrc   ir[11:8], ir[3:0]
//   alu_op        {ir[15:12], ir[7:4]}
//   imm_sel       ALU B operand is the immediate
//   imm           sign-extended ir[7:0]
//   flag_we       flag register update enable
//   flag_op       condition code handed to the PC
//   pc_add, pc_branch, pc_jump  PC commands, one-hot-or-zero
//   state         current FSM state, for debug
//
// state        | code | meaning
// S_FETCH      | 0    | PC addresses memory; wait for run
// S_DECODE     | 1    | instruction word arrives; latch into ir
// S_EXEC       | 2    | perform instruction, issue PC command (except LOAD)
// S_MEM        | 3    | LOAD write-back of memory data, then pc_add

module fsm_controller #(
  parameter int WIDTH   = 16,
  parameter int PC_BASE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [WIDTH-1:0] mem_rdata,
  input  logic [4:0]       flags,
  output logic [WIDTH-1:0] ir,
  output logic             mem_addr_sel,
  output logic             mem_we,
  output logic             rf_we,
  output logic [1:0]       wb_sel,
  output logic [3:0]       rdest,
  output logic [3:0]       rsrc,
  output logic [7:0]       alu_op,
  output logic             imm_sel,
  output logic [WIDTH-1:0] imm,
  output logic             flag_we,
  output logic [3:0]       flag_op,
  output logic             pc_add,
  output logic             pc_branch,
  output logic             pc_jump,
  output logic [2:0]       state
);

  // PC_BASE only documents where the PC starts; reject values the PC cannot hold.
  if (PC_BASE < 0 || PC_BASE >= (1 << WIDTH)) begin : gPcBaseRange
    $error("fsm_controller: PC_BASE does not fit in WIDTH bits");
  end

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3
  } state_t;

  typedef enum logic [2:0] {
    C_BCOND,
    C_JCOND,
    C_JAL,
    C_LOAD,
    C_STOR,
    C_ALU_REG,
    C_ALU_IMM,
    C_NOP
  } instrClass_t;

  state_t      curState;
  instrClass_t instrClass;
  logic [3:0]  cond;
  logic        condTrue;
  logic        flagN, flagZ, flagF, flagL, flagC;

  assign {flagN, flagZ, flagF, flagL, flagC} = flags;
  assign cond = ir[11:8];

  assign rdest  = ir[11:8];
  assign rsrc   = ir[3:0];
  assign alu_op = {ir[15:12], ir[7:4]};
  assign imm    = {{(WIDTH-8){ir[7]}}, ir[7:0]};
  assign state  = curState;

  // Decode priority: Bcond, then the 4'h4 extension group, then ALU forms.
  always_comb begin
    instrClass = C_ALU_IMM;
    if (ir[15:12] == 4'hC) begin
      instrClass = C_BCOND;
    end else if (ir[15:12] == 4'h4) begin
      case (ir[7:4])
        4'hC:    instrClass = C_JCOND;
        4'h8:    instrClass = C_JAL;
        4'h0:    instrClass = C_LOAD;
        4'h4:    instrClass = C_STOR;
        default: instrClass = C_NOP;
      endcase
    end else if (ir[15:12] == 4'h0) begin
      instrClass = C_ALU_REG;
    end
  end

  always_comb begin
    condTrue = 1'b0;
    case (cond)
      4'h0: condTrue = flagZ;
      4'h1: condTrue = !flagZ;
      4'h2: condTrue = flagC;
      4'h3: condTrue = !flagC;
      4'h4: condTrue = flagL;
      4'h5: condTrue = !flagL;
      4'h6: condTrue = flagN;
      4'h7: condTrue = !flagN;
      4'h8: condTrue = flagF;
      4'h9: condTrue = !flagF;
      4'hA: condTrue = !flagL && !flagZ;
      4'hB: condTrue = flagL || flagZ;
      4'hC: condTrue = !flagN && !flagZ;
      4'hD: condTrue = flagN || flagZ;
      4'hE: condTrue = 1'b1;
      default: condTrue = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      curState <= S_FETCH;
      ir       <= '0;
    end else begin
      case (curState)
        S_FETCH: begin
          if (run) curState <= S_DECODE;
        end
        S_DECODE: begin
          ir       <= mem_rdata;
          curState <= S_EXEC;
        end
        S_EXEC: begin
          curState <= (instrClass == C_LOAD) ? S_MEM : S_FETCH;
        end
        default: begin
          curState <= S_FETCH;
        end
      endcase
    end
  end

  // Strobes are gated by reset so an aborted instruction never writes.
  always_comb begin
    mem_addr_sel = 1'b0;
    mem_we       = 1'b0;
    rf_we        = 1'b0;
    wb_sel       = 2'b00;
    imm_sel      = 1'b0;
    flag_we      = 1'b0;
    flag_op      = 4'h0;
    pc_add       = 1'b0;
    pc_branch    = 1'b0;
    pc_jump      = 1'b0;
    if (!reset) begin
      case (curState)
        S_EXEC: begin
          case (instrClass)
            C_BCOND: begin
              if (condTrue) begin
                pc_branch = 1'b1;
                flag_op   = cond;
              end else begin
                pc_add = 1'b1;
              end
            end
            C_JCOND: begin
              pc_jump = 1'b1;
              flag_op = cond;
            end
            C_JAL: begin
              rf_we   = 1'b1;
              wb_sel  = 2'b10;
              pc_jump = 1'b1;
              flag_op = 4'hF;
            end
            C_LOAD: begin
              mem_addr_sel = 1'b1;
            end
            C_STOR: begin
              mem_addr_sel = 1'b1;
              mem_we       = 1'b1;
              pc_add       = 1'b1;
            end
            C_ALU_REG, C_ALU_IMM: begin
              rf_we   = 1'b1;
              flag_we = 1'b1;
              imm_sel = (instrClass == C_ALU_IMM);
              pc_add  = 1'b1;
            end
            default: begin
              pc_add = 1'b1;
            end
          endcase
        end
        S_MEM: begin
          rf_we        = 1'b1;
          wb_sel       = 2'b01;
          mem_addr_sel = 1'b1;
          pc_add       = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
